// File: rtl/serial_out.sv
// serial_out: row serializer. Reads rows 0..num_dp from a synchronous-read RAM
// and shifts the active fields of each row out one bit per clock, ascending
// from bit index `base`. Each next row is prefetched so the stream has no gaps.
module serial_out #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned MAX_FEATURES = 15,
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               start,
  input  logic [ADDR_WIDTH-1:0]              num_dp,
  input  logic [$clog2(MAX_FEATURES+1)-1:0]  feat,
  output logic [ADDR_WIDTH-1:0]              addr,
  output logic                               rd_en,
  input  logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               ser,
  output logic                               ser_valid,
  output logic                               last_row,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned FEAT_W = $clog2(MAX_FEATURES + 1);
  localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);
  localparam int unsigned BASE_W = IDX_W + 1;
  localparam int unsigned ROW_W  = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ0, S_WAIT0, S_SHIFT, S_FLUSH, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic                    ser_q, ser_d;
  logic                    ser_valid_q, ser_valid_d;
  logic                    last_row_q, last_row_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   next_buf_q, next_buf_d;
  logic                    cap_q, cap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [ADDR_WIDTH-1:0]   num_dp_q, num_dp_d;
  logic [FEAT_W-1:0]       feat_q, feat_d;

  logic [BASE_W-1:0]       nbits_c;
  logic [BASE_W-1:0]       base_c;
  logic [IDX_W-1:0]        base_idx_c;
  logic                    last_bit_c;
  logic                    more_c;
  logic                    first_c;

  // Row geometry and position decode from the latched transfer parameters
  always_comb begin
    nbits_c    = BASE_W'(LENGTH) * (BASE_W'(feat_q) + BASE_W'(1));
    base_c     = BASE_W'(DATA_WIDTH) - nbits_c;
    base_idx_c = IDX_W'(base_c);
    last_bit_c = (idx_q == IDX_W'(DATA_WIDTH - 1));
    more_c     = (row_q < ROW_W'(num_dp_q));
    first_c    = (idx_q == base_idx_c);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      ser_q       <= 1'b0;
      ser_valid_q <= 1'b0;
      last_row_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      next_buf_q  <= '0;
      cap_q       <= 1'b0;
      idx_q       <= '0;
      row_q       <= '0;
      num_dp_q    <= '0;
      feat_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_en_q     <= rd_en_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      last_row_q  <= last_row_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      next_buf_q  <= next_buf_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      num_dp_q    <= num_dp_d;
      feat_q      <= feat_d;
    end
  end

  // Next-state: the final bit of the last row drains through FLUSH into DONE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_READ0;
      S_READ0:        state_d = S_WAIT0;
      S_WAIT0:        state_d = S_SHIFT;
      S_SHIFT:        if (last_bit_c && !more_c) state_d = S_FLUSH;
      S_FLUSH:        state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: each edge in SHIFT emits shift_q[idx_q]
  always_comb begin
    addr_d      = addr_q;
    rd_en_d     = 1'b0;
    ser_d       = 1'b0;
    ser_valid_d = 1'b0;
    last_row_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    row_d       = row_q;
    num_dp_d    = num_dp_q;
    feat_d      = feat_q;
    // A prefetch read issued while shifting returns data one cycle later
    cap_d       = rd_en_q && (state_q == S_SHIFT);
    next_buf_d  = cap_q ? rd_data : next_buf_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          rd_en_d  = 1'b1;
          addr_d   = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          num_dp_d = num_dp;
          feat_d   = feat;
          row_d    = '0;
        end
      end
      S_READ0: begin
      end
      S_WAIT0: begin
        // First bit of row 0 goes straight from the RAM output
        shift_d     = rd_data;
        ser_d       = rd_data[base_idx_c];
        ser_valid_d = 1'b1;
        idx_d       = base_idx_c + IDX_W'(1);
        last_row_d  = (num_dp_q == '0);
        if (num_dp_q != '0) begin
          rd_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(1);
        end
      end
      S_SHIFT: begin
        ser_d       = shift_q[idx_q];
        ser_valid_d = 1'b1;
        idx_d       = idx_q + IDX_W'(1);
        last_row_d  = last_row_q;
        // First bit of rows 1..num_dp: update last_row and prefetch the next row
        if (first_c) begin
          last_row_d = (row_q == ROW_W'(num_dp_q));
          if (more_c) begin
            rd_en_d = 1'b1;
            addr_d  = ADDR_WIDTH'(row_q + ROW_W'(1));
          end
        end
        if (last_bit_c && more_c) begin
          shift_d = next_buf_q;
          idx_d   = base_idx_c;
          row_d   = row_q + ROW_W'(1);
        end
      end
      S_FLUSH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign addr      = addr_q;
  assign rd_en     = rd_en_q;
  assign ser       = ser_q;
  assign ser_valid = ser_valid_q;
  assign last_row  = last_row_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out with a synchronous-read RAM model and a
// stream monitor collecting every valid bit and every read address.
module tb_serial_out;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] num_dp;
  logic [3:0]    feat;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          ser;
  logic          ser_valid;
  logic          last_row;
  logic          busy;
  logic          done;

  serial_out dut (
    .CLK       (clk),
    .RST       (rst),
    .start     (start),
    .num_dp    (num_dp),
    .feat      (feat),
    .addr      (addr),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .ser       (ser),
    .ser_valid (ser_valid),
    .last_row  (last_row),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM
  logic [DW-1:0] mem [0:4095];
  initial rd_data = '0;
  always @(posedge clk) if (rd_en) rd_data <= mem[addr];

  // Stream monitor, sampled on the falling edge
  bit         bits_q[$];
  bit         lr_q[$];
  logic [AW-1:0] rd_q[$];
  int         rises = 0;
  int         bad_ser = 0;
  bit         prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rd_en) rd_q.push_back(addr);
    if (ser_valid) begin
      bits_q.push_back(ser);
      lr_q.push_back(last_row);
    end else if (ser !== 1'b0) begin
      bad_ser++;
    end
    if (ser_valid && !prev_valid) rises++;
    prev_valid = ser_valid;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits_q.delete();
    lr_q.delete();
    rd_q.delete();
    rises   = 0;
    bad_ser = 0;
  endtask

  task automatic fill(input int n);
    for (int r = 0; r < n; r++)
      for (int w = 0; w < 8; w++)
        mem[r][w*32 +: 32] = $urandom;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " addr"},      64'(addr),      64'd0);
    chk({tag, " rd_en"},     64'(rd_en),     64'd0);
    chk({tag, " ser"},       64'(ser),       64'd0);
    chk({tag, " ser_valid"}, 64'(ser_valid), 64'd0);
    chk({tag, " last_row"},  64'(last_row),  64'd0);
    chk({tag, " busy"},      64'(busy),      64'd0);
    chk({tag, " done"},      64'(done),      64'd0);
  endtask

  task automatic start_xfer(input int ndp, input int f);
    num_dp = AW'(ndp);
    feat   = 4'(f);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, " done reached"}, 64'(done), 64'd1);
  endtask

  // Compare collected stream, last_row flags and reads against the RAM image
  task automatic check_stream(input string tag, input int ndp, input int f);
    int nb    = 16 * (f + 1);
    int base  = DW - nb;
    int total = (ndp + 1) * nb;
    int bad   = 0;
    int lbad  = 0;
    int abad  = 0;
    chk({tag, " bit count"}, 64'(bits_q.size()), 64'(total));
    for (int k = 0; k < bits_q.size() && k < total; k++) begin
      if (bits_q[k] !== mem[k / nb][base + (k % nb)]) bad++;
      if (lr_q[k] !== (k >= total - nb)) lbad++;
    end
    chk({tag, " bit errors"},      64'(bad),  64'd0);
    chk({tag, " last_row errors"}, 64'(lbad), 64'd0);
    chk({tag, " read count"}, 64'(rd_q.size()), 64'(ndp + 1));
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== AW'(i)) abad++;
    chk({tag, " read addr errors"}, 64'(abad), 64'd0);
    chk({tag, " valid bursts"},     64'(rises), 64'd1);
    chk({tag, " ser idle nonzero"}, 64'(bad_ser), 64'd0);
  endtask

  initial begin
    logic [15:0] pat;
    bit          save_q[$];
    int          diff;

    rst    = 1'b1;
    start  = 1'b0;
    num_dp = '0;
    feat   = '0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // feat=0, one row, known pattern, exact cycle timing
    fill(1);
    mem[0][255:240] = 16'hA5C3;
    pat = 16'hA5C3;
    clear_mon();
    start_xfer(0, 0);
    chk("t1 E+1 rd_en", 64'(rd_en), 64'd1);
    chk("t1 E+1 addr",  64'(addr),  64'd0);
    chk("t1 E+1 busy",  64'(busy),  64'd1);
    step();
    chk("t1 E+2 ser_valid", 64'(ser_valid), 64'd0);
    chk("t1 E+2 rd_en",     64'(rd_en),     64'd0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("t1 bit%0d", i), 64'({ser_valid, last_row, ser}), 64'({2'b11, pat[i]}));
    end
    step();
    chk("t1 E+19 done",      64'(done),      64'd1);
    chk("t1 E+19 busy",      64'(busy),      64'd0);
    chk("t1 E+19 ser_valid", 64'(ser_valid), 64'd0);
    chk("t1 reads", 64'(rd_q.size()), 64'd1);

    // Full-width rows, three of them
    fill(3);
    clear_mon();
    start_xfer(2, 15);
    wait_done("t2", 2000);
    check_stream("t2", 2, 15);

    // feat=3, five rows; inputs and start perturbed mid-transfer
    fill(5);
    clear_mon();
    start_xfer(4, 3);
    repeat (10) step();
    feat   = 4'd7;
    num_dp = AW'(1);
    start  = 1'b1;
    step();
    start  = 1'b0;
    repeat (30) step();
    num_dp = AW'(9);
    start  = 1'b1;
    step();
    start  = 1'b0;
    wait_done("t3", 2000);
    check_stream("t3", 4, 3);

    // Reset during row 1 bit 7, then replay from row 0
    fill(3);
    clear_mon();
    start_xfer(2, 3);
    repeat (73) step();
    chk("t4 pre-reset bit", 64'({ser_valid, ser}), 64'({1'b1, mem[1][199]}));
    rst = 1'b1;
    step();
    chk_reset("t4 after reset");
    rst = 1'b0;
    clear_mon();
    repeat (5) step();
    chk("t4 no reads after reset", 64'(rd_q.size()), 64'd0);
    clear_mon();
    start_xfer(2, 3);
    wait_done("t4 replay", 2000);
    check_stream("t4 replay", 2, 3);

    // Restart from DONE repeats the identical stream
    save_q = bits_q;
    clear_mon();
    start_xfer(2, 3);
    chk("t5 done cleared", 64'(done), 64'd0);
    chk("t5 busy",         64'(busy), 64'd1);
    wait_done("t5", 2000);
    check_stream("t5", 2, 3);
    diff = 0;
    for (int k = 0; k < save_q.size() && k < bits_q.size(); k++)
      if (save_q[k] !== bits_q[k]) diff++;
    chk("t5 repeat length", 64'(bits_q.size()), 64'(save_q.size()));
    chk("t5 repeat diffs",  64'(diff), 64'd0);

    // Maximum row count
    fill(4096);
    clear_mon();
    start_xfer(4095, 0);
    wait_done("t6", 70000);
    check_stream("t6", 4095, 0);
    chk("t6 addr holds last", 64'(addr), 64'hFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
